// File: rtl/display_scanner_pkg.sv
// Shared widths, limits and the BCD digit bundle for the display scanner.
// LEADING_ZERO_BLANK_EN (optional) blanks leading-zero positions in the scan.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W = 4;
    localparam int BIN_W = 14;
    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_digits_t;

    // Double-dabble correction: any nibble >= 5 would overflow after the shift.
    function automatic bcd_digits_t dabble_adjust(bcd_digits_t a);
        bcd_digits_t r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i] = (a[i] >= BCD_W'(5)) ? a[i] + BCD_W'(3) : a[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load handshake, status flags and scan outputs of the display scanner.
// LEADING_ZERO_BLANK_EN affects only how the DUT drives an.
interface display_scanner_if;
    import display_pkg::*;

    logic                  load;
    logic [BIN_W-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [BCD_W-1:0]      digit;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output load, value,
        input  busy, done, ovf, digit, an
    );

    modport slave (
        input  load, value,
        output busy, done, ovf, digit, an
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
// done strobes in the cycle before the engine returns idle.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output bcd_digits_t      bcd
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    bcd_digits_t           acc_q, acc_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS*BCD_W-1:0] adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        adj     = dabble_adjust(acc_q);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = {adj[NUM_DIGITS*BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(BIN_W - 1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bcd = acc_q;

endmodule

// File: rtl/display_scanner.sv
// Saturating load, BCD conversion and 4-digit multiplexed scan for the display.
// LEADING_ZERO_BLANK_EN: darken positions above the most significant nonzero digit.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic             start;
    logic             sat;
    logic [BIN_W-1:0] bin_sat;
    logic             conv_busy;
    logic             conv_done;
    bcd_digits_t      conv_bcd;

    bcd_digits_t      disp_q, disp_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lit;

    assign start   = bus.load & ~conv_busy;
    assign sat     = (bus.value > MAX_VAL);
    assign bin_sat = sat ? MAX_VAL : bus.value;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin_sat),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            disp_q <= disp_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;
        done_d = conv_done;
        ovf_d  = start ? sat : ovf_q;
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A slot stays lit if it or any higher position holds a nonzero digit.
    always_comb begin
        lit = (idx_q == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && disp_q[i] != '0) begin
                lit = 1'b1;
            end
        end
    end
`else
    assign lit = 1'b1;
`endif

    assign bus.an    = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    assign bus.digit = disp_q[idx_q];
    assign bus.busy  = conv_busy;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with REFRESH_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when computing expected anode patterns.
module tb_display_scanner;

    logic clk = 1'b0;
    logic rst = 1'b0;

    display_scanner_if bus();

    display_scanner #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; gives the expected scan slot.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_check(input string tag, input logic [15:0] d,
                              input int nlit);
        int idx;
        logic [3:0] one;
        logic [3:0] exp_an;
        one = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            tick();
            idx = (cyc / 4) % 4;
            exp_an = ~(one << idx);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx >= nlit) exp_an = 4'hF;
`endif
            check($sformatf("%s an slot%0d", tag, idx), {28'd0, bus.an},
                  {28'd0, exp_an});
            check($sformatf("%s digit slot%0d", tag, idx), {28'd0, bus.digit},
                  {28'd0, d[idx*4 +: 4]});
        end
    endtask

    task automatic convert(input string tag, input logic [13:0] v,
                           input int drop_at, input logic [13:0] v2,
                           input logic exp_ovf, input logic [15:0] d,
                           input int nlit);
        int ndone;
        int first_done;
        int first_idle;
        bus.load  = 1'b1;
        bus.value = v;
        tick();
        bus.load  = 1'b0;
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
        ndone = 0;
        first_done = 0;
        first_idle = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == drop_at) begin
                bus.load  = 1'b1;
                bus.value = v2;
            end
            tick();
            bus.load = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (!bus.busy && first_idle == 0) first_idle = k;
        end
        check({tag, " done count"}, ndone, 1);
        check({tag, " done latency"}, first_done, 15);
        check({tag, " busy length"}, first_idle, 15);
        check({tag, " ovf hold"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
        scan_check(tag, d, nlit);
    endtask

    initial begin
        int ndone;
        bus.load  = 1'b0;
        bus.value = '0;
        #1 rst = 1'b1;
        #1;
        check("rst an", {28'd0, bus.an}, 32'hE);
        check("rst digit", {28'd0, bus.digit}, 32'h0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst ovf", {31'd0, bus.ovf}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        convert("n1234", 14'd1234, 0, 14'd0, 1'b0, 16'h1234, 4);
        convert("ovf12000", 14'd12000, 0, 14'd0, 1'b1, 16'h9999, 4);
        convert("small5", 14'd5, 0, 14'd0, 1'b0, 16'h0005, 1);
        convert("ovf10000", 14'd10000, 0, 14'd0, 1'b1, 16'h9999, 4);
        convert("drop", 14'd42, 5, 14'd77, 1'b0, 16'h0042, 2);
        convert("lz7", 14'd7, 0, 14'd0, 1'b0, 16'h0007, 1);
        convert("max9999", 14'd9999, 0, 14'd0, 1'b0, 16'h9999, 4);

        // Abort a conversion of 9999 during its eighth cycle.
        bus.load  = 1'b1;
        bus.value = 14'd12000;
        tick();
        bus.load  = 1'b0;
        check("abort ovf set", {31'd0, bus.ovf}, 32'd1);
        repeat (7) tick();
        #3 rst = 1'b1;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort ovf", {31'd0, bus.ovf}, 32'd0);
        check("abort an", {28'd0, bus.an}, 32'hE);
        check("abort digit", {28'd0, bus.digit}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.done) ndone++;
        end
        check("abort no done", ndone, 0);
        check("abort busy idle", {31'd0, bus.busy}, 32'd0);
        scan_check("abort zero", 16'h0000, 1);
        convert("after rst", 14'd9999, 0, 14'd0, 1'b0, 16'h9999, 4);
        convert("after rst2", 14'd308, 0, 14'd0, 1'b0, 16'h0308, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
